// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared opcodes, FSM states and ALU encodings for the multi-cycle core control
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational ALUOp/funct decode to ALU operation code
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 only means sub for R-type; addi reuses that bit as immediate
          3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM of the multi-cycle RV32I core
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [6:0]      op,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            zero,
  input  logic            mem_ready,
  output logic [2:0]      ALUControl,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ResultSrc,
  output logic [1:0]      ImmSrc,
  output logic            AdrSrc,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            illegal_instr,
  output logic [XLEN-1:0] instret_count
);

  state_t  state;
  alu_op_t alu_op;
  logic    ir_write_s, pc_update_s, branch_s, reg_write_s, mem_write_s;
  logic    retire;

  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                  ((state == S_MEMWRITE) && mem_ready);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_FETCH;
      illegal_instr <= 1'b0;
      instret_count <= '0;
    end else begin
      illegal_instr <= 1'b0;
      if (retire) instret_count <= instret_count + XLEN'(1);
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_RTYPE:          state <= S_EXECR;
            OP_ITYPE:          state <= S_EXECI;
            OP_BRANCH:         state <= S_BEQ;
            OP_JAL:            state <= S_JAL;
            default: begin
              state         <= S_FETCH;
              illegal_instr <= 1'b1;
            end
          endcase
        end
        S_MEMADR:   state <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BEQ:      state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        default:    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    AdrSrc      = 1'b0;
    alu_op      = ALUOP_ADD;
    ir_write_s  = 1'b0;
    pc_update_s = 1'b0;
    branch_s    = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        ir_write_s  = mem_ready;
        pc_update_s = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB:    reg_write_s = 1'b1;
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        alu_op   = ALUOP_SUB;
        branch_s = 1'b1;
      end
      S_JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        pc_update_s = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are gated by resetn so nothing can write while reset is held
  assign IRWrite  = resetn & ir_write_s;
  assign PCWrite  = resetn & (pc_update_s | (branch_s & zero));
  assign RegWrite = resetn & reg_write_s;
  assign MemWrite = resetn & mem_write_s;

  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
      OP_JAL:    ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op     (alu_op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alu_control(ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic        clk, resetn, funct7b5, zero, mem_ready;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [2:0]  ALUControl;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic        AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal_instr;
  logic [31:0] instret_count;
  logic [13:0] obs;
  int          checks = 0;
  int          failures = 0;

  multicycle_controller #(.XLEN(32)) dut (
    .clk(clk), .resetn(resetn), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .illegal_instr(illegal_instr), .instret_count(instret_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {ALUControl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite};

  // Expected control word per state; ae is the hand-derived ALUControl for the exec states
  function automatic logic [13:0] sig(input int st, input logic mr, input logic z, input logic [2:0] ae);
    logic [1:0] a, b, r;
    logic [2:0] alu;
    logic adr, ir, pc, rw, mw;
    a = 2'b00; b = 2'b00; r = 2'b00; alu = 3'b000;
    adr = 1'b0; ir = 1'b0; pc = 1'b0; rw = 1'b0; mw = 1'b0;
    case (st)
      0: begin b = 2'b10; r = 2'b10; ir = mr; pc = mr; end
      1: begin a = 2'b01; b = 2'b01; end
      2: begin a = 2'b10; b = 2'b01; end
      3: adr = 1'b1;
      4: begin r = 2'b01; rw = 1'b1; end
      5: begin adr = 1'b1; mw = 1'b1; end
      6: begin a = 2'b10; alu = ae; end
      7: begin a = 2'b10; b = 2'b01; alu = ae; end
      8: rw = 1'b1;
      9: begin a = 2'b10; alu = 3'b001; pc = z; end
      10: begin a = 2'b01; b = 2'b10; pc = 1'b1; end
      default: ;
    endcase
    return {alu, a, b, r, adr, ir, pc, rw, mw};
  endfunction

  task automatic test_reset();
    resetn = 1'b0; mem_ready = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== sig(0, 1'b0, 1'b0, 3'b000)) begin
      failures++; $display("FAIL reset_outputs got=%h exp=%h", obs, sig(0, 1'b0, 1'b0, 3'b000));
    end
    checks++;
    if (instret_count !== 32'd0 || illegal_instr !== 1'b0) begin
      failures++; $display("FAIL reset_counters got=%0d/%b exp=0/0", instret_count, illegal_instr);
    end
    mem_ready = 1'b0;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    int st[4] = '{0, 1, 6, 8};
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== sig(st[i], 1'b1, zero, 3'b001)) begin
        failures++; $display("FAIL rtype_step%0d got=%h exp=%h", i, obs, sig(st[i], 1'b1, zero, 3'b001));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (instret_count !== 32'd1) begin
      failures++; $display("FAIL rtype_instret got=%0d exp=1", instret_count);
    end
  endtask

  task automatic test_lw_wait();
    int   st[8] = '{0, 1, 2, 3, 3, 3, 3, 4};
    logic mr[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i];
      @(negedge clk);
      checks++;
      if (obs !== sig(st[i], mr[i], zero, 3'b000)) begin
        failures++; $display("FAIL lw_step%0d got=%h exp=%h", i, obs, sig(st[i], mr[i], zero, 3'b000));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (instret_count !== 32'd2) begin
      failures++; $display("FAIL lw_instret got=%0d exp=2", instret_count);
    end
  endtask

  task automatic test_sw_wait();
    int   st[6] = '{0, 1, 2, 5, 5, 5};
    logic mr[6] = '{1, 1, 1, 0, 0, 1};
    int   mw_cycles = 0;
    op = 7'b0100011; funct3 = 3'b010;
    for (int i = 0; i < 6; i++) begin
      mem_ready = mr[i];
      @(negedge clk);
      if (MemWrite === 1'b1) mw_cycles++;
      checks++;
      if (obs !== sig(st[i], mr[i], zero, 3'b000) || ImmSrc !== 2'b01) begin
        failures++; $display("FAIL sw_step%0d got=%h/%b exp=%h/01", i, obs, ImmSrc, sig(st[i], mr[i], zero, 3'b000));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (mw_cycles != 3 || instret_count !== 32'd3) begin
      failures++; $display("FAIL sw_memwrite_len got=%0d/%0d exp=3/3", mw_cycles, instret_count);
    end
  endtask

  task automatic test_beq();
    int st[3] = '{0, 1, 9};
    op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      zero = (pass == 0);
      for (int i = 0; i < 3; i++) begin
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== sig(st[i], 1'b1, zero, 3'b000) || ImmSrc !== 2'b10) begin
          failures++; $display("FAIL beq_z%0d_step%0d got=%h/%b exp=%h/10", zero, i, obs, ImmSrc, sig(st[i], 1'b1, zero, 3'b000));
        end
        @(posedge clk); #1;
      end
      checks++;
      if (instret_count !== 32'(4 + pass)) begin
        failures++; $display("FAIL beq_instret got=%0d exp=%0d", instret_count, 4 + pass);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jal();
    int st[4] = '{0, 1, 10, 8};
    op = 7'b1101111;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== sig(st[i], 1'b1, zero, 3'b000) || ImmSrc !== 2'b11) begin
        failures++; $display("FAIL jal_step%0d got=%h/%b exp=%h/11", i, obs, ImmSrc, sig(st[i], 1'b1, zero, 3'b000));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (instret_count !== 32'd6) begin
      failures++; $display("FAIL jal_instret got=%0d exp=6", instret_count);
    end
  endtask

  task automatic test_illegal();
    int   st[4]  = '{0, 1, 0, 0};
    logic mr[4]  = '{1, 1, 0, 0};
    logic ill[4] = '{0, 0, 1, 0};
    op = 7'b1111111;
    for (int i = 0; i < 4; i++) begin
      mem_ready = mr[i];
      @(negedge clk);
      checks++;
      if (obs !== sig(st[i], mr[i], zero, 3'b000) || illegal_instr !== ill[i]) begin
        failures++; $display("FAIL illegal_step%0d got=%h/%b exp=%h/%b", i, obs, illegal_instr, sig(st[i], mr[i], zero, 3'b000), ill[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (instret_count !== 32'd6) begin
      failures++; $display("FAIL illegal_instret got=%0d exp=6", instret_count);
    end
  endtask

  task automatic test_reset_mid_store();
    op = 7'b0100011;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (MemWrite !== 1'b1) begin
      failures++; $display("FAIL midrst_pre got=%b exp=1", MemWrite);
    end
    mem_ready = 1'b1;
    resetn = 1'b0;
    #1;
    checks++;
    if (obs !== sig(0, 1'b0, 1'b0, 3'b000) || instret_count !== 32'd0) begin
      failures++; $display("FAIL midrst_post got=%h/%0d exp=%h/0", obs, instret_count, sig(0, 1'b0, 1'b0, 3'b000));
    end
    mem_ready = 1'b0;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_itype_sweep();
    int         st[4] = '{0, 1, 7, 8};
    logic [2:0] f3[4] = '{3'b000, 3'b010, 3'b110, 3'b111};
    logic [2:0] ex[4] = '{3'b000, 3'b101, 3'b110, 3'b010};
    op = 7'b0010011; funct7b5 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      funct3 = f3[k];
      for (int i = 0; i < 4; i++) begin
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== sig(st[i], 1'b1, zero, ex[k])) begin
          failures++; $display("FAIL itype_f3_%0d_step%0d got=%h exp=%h", k, i, obs, sig(st[i], 1'b1, zero, ex[k]));
        end
        @(posedge clk); #1;
      end
    end
    checks++;
    if (instret_count !== 32'd4) begin
      failures++; $display("FAIL itype_instret got=%0d exp=4", instret_count);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_wait();
    test_beq();
    test_jal();
    test_illegal();
    test_reset_mid_store();
    test_itype_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
